// File: rtl/spi_engine_execution_sdi_data_disassemble_pkg.sv
// rtl/spi_engine_execution_sdi_data_disassemble_pkg.sv - shared lane/command constants, FSM states and helpers
package spi_engine_execution_sdi_data_disassemble_pkg;

  localparam int         MAX_LANES                   = 8;
  localparam logic [2:0] CMD_WRITE_DEF               = 3'b010;
  localparam logic [1:0] REG_SPI_LANE_CONFIG_DEF     = 2'b11;
  localparam int         CMD_INSTR_MSB               = 14;
  localparam int         CMD_INSTR_LSB               = 12;
  localparam int         CMD_REG_MSB                 = 9;
  localparam int         CMD_REG_LSB                 = 8;
  localparam int         CMD_MASK_MSB                = 7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < MAX_LANES; k++) c = c + {3'b000, m[k]};
    return c;
  endfunction

  // True when no mask bit above lane is set.
  function automatic logic is_last_lane(input logic [7:0] m, input logic [2:0] lane);
    return ((m >> lane) >> 1) == 8'h00;
  endfunction

endpackage

// File: rtl/spi_engine_execution_sdi_data_disassemble_if.sv
// rtl/spi_engine_execution_sdi_data_disassemble_if.sv - capture input and sdi_data output stream bundle
interface spi_engine_execution_sdi_data_disassemble_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_OF_SDI = 1
);
  logic                             capture_valid;
  logic [NUM_OF_SDI*DATA_WIDTH-1:0] capture_data;
  logic                             capture_ready;
  logic [DATA_WIDTH-1:0]            sdi_data;
  logic                             sdi_data_valid;
  logic                             sdi_data_ready;
  logic                             sdi_last_lane;

  modport slave (
    input  capture_valid, capture_data, sdi_data_ready,
    output capture_ready, sdi_data, sdi_data_valid, sdi_last_lane
  );

  modport master (
    output capture_valid, capture_data, sdi_data_ready,
    input  capture_ready, sdi_data, sdi_data_valid, sdi_last_lane
  );
endinterface

// File: rtl/spi_engine_lane_pick.sv
// rtl/spi_engine_lane_pick.sv - lowest set mask bit above cur_lane (or from 0 when first)
module spi_engine_lane_pick
  import spi_engine_execution_sdi_data_disassemble_pkg::*;
(
  input  logic [7:0] mask_i,
  input  logic [2:0] cur_lane_i,
  input  logic       first_i,
  output logic [2:0] lane_o,
  output logic       none_left_o
);

  // Scan downward so the lowest qualifying bit is the one that sticks.
  always_comb begin
    lane_o      = 3'd0;
    none_left_o = 1'b1;
    for (int k = MAX_LANES - 1; k >= 0; k--) begin
      if (mask_i[k] && (first_i || (k > int'(cur_lane_i)))) begin
        lane_o      = 3'(k);
        none_left_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_engine_execution_sdi_data_disassemble.sv
// rtl/spi_engine_execution_sdi_data_disassemble.sv - serialises a multi-lane SDI capture into per-lane words
module spi_engine_execution_sdi_data_disassemble
  import spi_engine_execution_sdi_data_disassemble_pkg::*;
#(
  parameter int         DATA_WIDTH           = 8,
  parameter int         NUM_OF_SDI           = 1,
  parameter logic [7:0] ALL_ACTIVE_LANE_MASK = 8'hFF,
  parameter logic [2:0] CMD_WRITE            = CMD_WRITE_DEF,
  parameter logic [1:0] REG_SPI_LANE_CONFIG  = REG_SPI_LANE_CONFIG_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  input  logic [15:0] current_cmd,
  spi_engine_execution_sdi_data_disassemble_if.slave bus,
  output logic [7:0]  lane_mask,
  output logic [3:0]  num_active_lanes
);

  localparam logic [7:0] LANE_LIMIT = 8'((16'd1 << NUM_OF_SDI) - 16'd1);
  localparam logic [7:0] RESET_MASK = ALL_ACTIVE_LANE_MASK & LANE_LIMIT;
  localparam int         CAP_W      = NUM_OF_SDI * DATA_WIDTH;

  state_e                 state_q, state_d;
  logic [CAP_W-1:0]       data_q, data_d;
  logic [7:0]             snap_mask_q, snap_mask_d;
  logic [2:0]             cur_lane_q, cur_lane_d;
  logic [DATA_WIDTH-1:0]  sdi_data_q, sdi_data_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [7:0]             lane_mask_q, lane_mask_d;
  logic [3:0]             num_q, num_d;

  logic       cfg_hit, beat_fire, cap_fire, load;
  logic [7:0] cfg_masked;
  logic [2:0] first_lane, next_lane;
  logic       first_none, next_none;
  logic       unused_cmd_bits;

  assign unused_cmd_bits = ^{current_cmd[15], current_cmd[11:10]};

  function automatic logic [DATA_WIDTH-1:0] lane_word(input logic [CAP_W-1:0] d, input logic [2:0] lane);
    lane_word = '0;
    for (int k = 0; k < NUM_OF_SDI; k++)
      if (lane == 3'(k)) lane_word = d[k*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  spi_engine_lane_pick u_pick_first (
    .mask_i      (lane_mask_q),
    .cur_lane_i  (3'd0),
    .first_i     (1'b1),
    .lane_o      (first_lane),
    .none_left_o (first_none)
  );

  spi_engine_lane_pick u_pick_next (
    .mask_i      (snap_mask_q),
    .cur_lane_i  (cur_lane_q),
    .first_i     (1'b0),
    .lane_o      (next_lane),
    .none_left_o (next_none)
  );

  assign beat_fire         = valid_q && bus.sdi_data_ready;
  assign bus.capture_ready = (state_q == ST_IDLE) || (beat_fire && last_q);
  assign cap_fire          = bus.capture_valid && bus.capture_ready;

  assign cfg_hit    = cmd_valid
                   && (current_cmd[CMD_INSTR_MSB:CMD_INSTR_LSB] == CMD_WRITE)
                   && (current_cmd[CMD_REG_MSB:CMD_REG_LSB] == REG_SPI_LANE_CONFIG);
  assign cfg_masked = current_cmd[CMD_MASK_MSB:0] & LANE_LIMIT;

  always_comb begin
    lane_mask_d = lane_mask_q;
    num_d       = num_q;
    if (cfg_hit) begin
      lane_mask_d = (cfg_masked == 8'h00) ? 8'h01 : cfg_masked;
      num_d       = popcount8(lane_mask_d);
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    snap_mask_d = snap_mask_q;
    cur_lane_d  = cur_lane_q;
    sdi_data_d  = sdi_data_q;
    valid_d     = valid_q;
    last_d      = last_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cap_fire) load = 1'b1;
      end
      ST_DRAIN: begin
        if (beat_fire) begin
          if (last_q || next_none) begin
            if (cap_fire) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end
          end else begin
            cur_lane_d = next_lane;
            sdi_data_d = lane_word(data_q, next_lane);
            last_d     = is_last_lane(snap_mask_q, next_lane);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The mask in force before any same-cycle config write is the one snapshotted.
    if (load) begin
      state_d     = ST_DRAIN;
      data_d      = bus.capture_data;
      snap_mask_d = lane_mask_q;
      cur_lane_d  = first_lane;
      sdi_data_d  = lane_word(bus.capture_data, first_lane);
      valid_d     = !first_none;
      last_d      = is_last_lane(lane_mask_q, first_lane);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      snap_mask_q <= '0;
      cur_lane_q  <= '0;
      sdi_data_q  <= '0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      lane_mask_q <= RESET_MASK;
      num_q       <= popcount8(RESET_MASK);
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      snap_mask_q <= snap_mask_d;
      cur_lane_q  <= cur_lane_d;
      sdi_data_q  <= sdi_data_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      lane_mask_q <= lane_mask_d;
      num_q       <= num_d;
    end
  end

  assign bus.sdi_data       = sdi_data_q;
  assign bus.sdi_data_valid = valid_q;
  assign bus.sdi_last_lane  = last_q;
  assign lane_mask          = lane_mask_q;
  assign num_active_lanes   = num_q;

endmodule

// File: tb/tb_spi_engine_execution_sdi_data_disassemble.sv
// tb/tb_spi_engine_execution_sdi_data_disassemble.sv - directed bench for the SDI lane disassembler
module tb_spi_engine_execution_sdi_data_disassemble;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cmd_valid;
  logic [15:0] current_cmd;
  logic [7:0]  lane_mask;
  logic [3:0]  num_active_lanes;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  spi_engine_execution_sdi_data_disassemble_if #(.DATA_WIDTH(8), .NUM_OF_SDI(4)) bus ();

  spi_engine_execution_sdi_data_disassemble #(
    .DATA_WIDTH(8),
    .NUM_OF_SDI(4),
    .ALL_ACTIVE_LANE_MASK(8'hFF),
    .CMD_WRITE(3'b010),
    .REG_SPI_LANE_CONFIG(2'b11)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .cmd_valid        (cmd_valid),
    .current_cmd      (current_cmd),
    .bus              (bus),
    .lane_mask        (lane_mask),
    .num_active_lanes (num_active_lanes)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [7:0] d, input logic last);
    chk({tag, "_valid"}, 32'(bus.sdi_data_valid), 32'd1);
    chk({tag, "_data"},  32'(bus.sdi_data), 32'(d));
    chk({tag, "_last"},  32'(bus.sdi_last_lane), 32'(last));
  endtask

  task automatic cfg(input logic [7:0] m);
    cmd_valid   = 1'b1;
    current_cmd = {1'b0, 3'b010, 2'b00, 2'b11, m};
    step();
    cmd_valid   = 1'b0;
    current_cmd = 16'h0000;
  endtask

  initial begin
    resetn             = 1'b0;
    cmd_valid          = 1'b0;
    current_cmd        = 16'h0000;
    bus.capture_valid  = 1'b0;
    bus.capture_data   = 32'h0;
    bus.sdi_data_ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.sdi_data_valid), 32'd0);
    chk("rst_data",  32'(bus.sdi_data), 32'd0);
    chk("rst_last",  32'(bus.sdi_last_lane), 32'd0);
    chk("rst_cready", 32'(bus.capture_ready), 32'd1);
    chk("rst_mask",  32'(lane_mask), 32'h0F);
    chk("rst_num",   32'(num_active_lanes), 32'd4);
    resetn = 1'b1;
    step();

    // Full mask, four beats
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    bus.capture_valid = 1'b0;
    chk_beat("f0", 8'h11, 1'b0);
    chk("f0_cready", 32'(bus.capture_ready), 32'd0);
    step();
    chk_beat("f1", 8'h22, 1'b0);
    step();
    chk_beat("f2", 8'h33, 1'b0);
    step();
    chk_beat("f3", 8'h44, 1'b1);
    chk("f3_cready", 32'(bus.capture_ready), 32'd1);
    step();
    chk("f_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Mask 0x5
    cfg(8'h05);
    chk("m5_mask", 32'(lane_mask), 32'h05);
    chk("m5_num",  32'(num_active_lanes), 32'd2);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    bus.capture_valid = 1'b0;
    chk_beat("m5_0", 8'h11, 1'b0);
    step();
    chk_beat("m5_1", 8'h33, 1'b1);
    step();
    chk("m5_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Mask 0x8, back-to-back captures
    cfg(8'h08);
    chk("m8_num", 32'(num_active_lanes), 32'd1);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'hAA000000;
    step();
    bus.capture_data  = 32'hBB000000;
    chk_beat("m8_a", 8'hAA, 1'b1);
    chk("m8_a_cready", 32'(bus.capture_ready), 32'd1);
    step();
    bus.capture_valid = 1'b0;
    chk_beat("m8_b", 8'hBB, 1'b1);
    step();
    chk("m8_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Backpressure mid-drain with a competing capture held off
    cfg(8'h0F);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    bus.capture_data  = 32'h99999999;
    chk_beat("bp0", 8'h11, 1'b0);
    step();
    chk_beat("bp1", 8'h22, 1'b0);
    bus.sdi_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("bp_hold", 8'h22, 1'b0);
      chk("bp_hold_cready", 32'(bus.capture_ready), 32'd0);
    end
    bus.capture_valid  = 1'b0;
    bus.sdi_data_ready = 1'b1;
    step();
    chk_beat("bp2", 8'h33, 1'b0);
    step();
    chk_beat("bp3", 8'h44, 1'b1);
    step();
    chk("bp_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Zero mask stored as lane 0
    cfg(8'h00);
    chk("m0_mask", 32'(lane_mask), 32'h01);
    chk("m0_num",  32'(num_active_lanes), 32'd1);

    // Config write during drain only affects the next capture
    cfg(8'h0F);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    bus.capture_valid = 1'b0;
    cmd_valid   = 1'b1;
    current_cmd = 16'h2303;
    chk_beat("cd0", 8'h11, 1'b0);
    step();
    cmd_valid   = 1'b0;
    current_cmd = 16'h0000;
    chk_beat("cd1", 8'h22, 1'b0);
    chk("cd_mask", 32'(lane_mask), 32'h03);
    chk("cd_num",  32'(num_active_lanes), 32'd2);
    step();
    chk_beat("cd2", 8'h33, 1'b0);
    step();
    chk_beat("cd3", 8'h44, 1'b1);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h88776655;
    step();
    bus.capture_valid = 1'b0;
    chk_beat("cd_n0", 8'h55, 1'b0);
    step();
    chk_beat("cd_n1", 8'h66, 1'b1);
    step();
    chk("cd_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Simultaneous config write and capture uses the old mask (0x3)
    cmd_valid         = 1'b1;
    current_cmd       = 16'h2304;
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    cmd_valid         = 1'b0;
    bus.capture_valid = 1'b0;
    chk_beat("sim0", 8'h11, 1'b0);
    chk("sim_mask", 32'(lane_mask), 32'h04);
    step();
    chk_beat("sim1", 8'h22, 1'b1);
    step();
    chk("sim_end_valid", 32'(bus.sdi_data_valid), 32'd0);

    // Reset with beat 2 of 4 pending
    cfg(8'h0F);
    bus.capture_valid = 1'b1;
    bus.capture_data  = 32'h44332211;
    step();
    bus.capture_valid = 1'b0;
    chk_beat("rd0", 8'h11, 1'b0);
    step();
    chk_beat("rd1", 8'h22, 1'b0);
    cfg(8'h01);
    resetn = 1'b0;
    step();
    chk("rd_valid",  32'(bus.sdi_data_valid), 32'd0);
    chk("rd_cready", 32'(bus.capture_ready), 32'd1);
    chk("rd_data",   32'(bus.sdi_data), 32'd0);
    chk("rd_last",   32'(bus.sdi_last_lane), 32'd0);
    chk("rd_mask",   32'(lane_mask), 32'h0F);
    chk("rd_num",    32'(num_active_lanes), 32'd4);
    resetn = 1'b1;
    step();
    chk("rd_idle_valid", 32'(bus.sdi_data_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
